// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned, start/done handshake
// Ports: clk; reset (async, active-low); start, is_signed, Divsrca (dividend), Divsrcb (divisor) sampled in IDLE;
//        busy (operation in flight), done (one-cycle result pulse), DivHI (remainder), DivLO (quotient),
//        by_zero (last completed operation divided by zero).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] Divsrca,
    input  logic [WIDTH-1:0] Divsrcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DivHI,
    output logic [WIDTH-1:0] DivLO,
    output logic             by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, mag_b;
    logic             neg_q, neg_r, zero;
    logic [WIDTH-1:0] mag_a, mag_b_in;
    logic [WIDTH:0]   trial;
    always_comb begin
        mag_a    = (is_signed && Divsrca[WIDTH-1]) ? -Divsrca : Divsrca;
        mag_b_in = (is_signed && Divsrcb[WIDTH-1]) ? -Divsrcb : Divsrcb;
        // borrow out in the top bit means the shifted remainder is below the divisor
        trial    = {rem, quo[WIDTH-1]} - {1'b0, mag_b};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            mag_b   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            DivHI   <= '0;
            DivLO   <= '0;
            by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy  <= 1'b1;
                    neg_q <= is_signed & (Divsrca[WIDTH-1] ^ Divsrcb[WIDTH-1]);
                    neg_r <= is_signed & Divsrca[WIDTH-1];
                    zero  <= (Divsrcb == '0);
                    mag_b <= mag_b_in;
                    rem   <= '0;
                    cnt   <= CNT_W'(WIDTH);
                    // on divide-by-zero the raw dividend rides in quo straight to DivHI
                    quo   <= (Divsrcb == '0) ? Divsrca : mag_a;
                    state <= (Divsrcb == '0) ? FIX : RUN;
                end
                RUN: begin
                    rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt - CNT_W'(1);
                    state <= (cnt == CNT_W'(1)) ? FIX : RUN;
                end
                FIX: begin
                    DivLO   <= zero ? '0 : (neg_q ? -quo : quo);
                    DivHI   <= zero ? quo : (neg_r ? -rem : rem);
                    by_zero <= zero;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed, model-checked bench for seq_divider (WIDTH=32 and WIDTH=8)
module tb_seq_divider;
    typedef struct packed {
        int          e0;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        bz;
    } exp_t;

    logic        clk = 0, reset = 1;
    logic        start = 0, sg = 0;
    logic [31:0] a = 0, b = 0, hi, lo;
    logic        busy, done, bz;
    logic        start8 = 0, sg8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, hi8, lo8;
    logic        busy8, done8, bz8;
    int          edges = 0, n_cmp = 0, n_err = 0;
    exp_t        q[$];
    exp_t        last = '0;
    logic        exp_busy, exp_done;

    seq_divider dut (.clk(clk), .reset(reset), .start(start), .is_signed(sg), .Divsrca(a), .Divsrcb(b),
                     .busy(busy), .done(done), .DivHI(hi), .DivLO(lo), .by_zero(bz));
    seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .is_signed(sg8), .Divsrca(a8),
                     .Divsrcb(b8), .busy(busy8), .done(done8), .DivHI(hi8), .DivLO(lo8), .by_zero(bz8));

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edges);
        end
    endtask

    // returns {by_zero, remainder, quotient} from magnitudes and sign rules
    function automatic logic [64:0] model(input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
        longint unsigned m, ua, ub, ma, mb, qq, rr;
        logic na, nb;
        m  = (64'd1 << w) - 1;
        ua = {32'd0, x} & m;
        ub = {32'd0, y} & m;
        if (ub == 0) return {1'b1, ua[31:0], 32'd0};
        na = s && ua[w-1];
        nb = s && ub[w-1];
        ma = na ? ((~ua + 1) & m) : ua;
        mb = nb ? ((~ub + 1) & m) : ub;
        qq = ma / mb;
        rr = ma % mb;
        if (na ^ nb) qq = (~qq + 1) & m;
        if (na) rr = (~rr + 1) & m;
        return {1'b0, rr[31:0], qq[31:0]};
    endfunction

    function automatic exp_t mk(input int e0, input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [64:0] m;
        m     = model(32, s, x, y);
        e.e0  = e0;
        e.due = e0 + ((y == 0) ? 1 : 33);
        e.bz  = m[64];
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        return e;
    endfunction

    // single compare process for the 32-bit instance, every cycle
    always @(negedge clk) begin
        if (q.size() > 0 && edges > q[0].due) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_missing: got no done expected done at edge %0d", q[0].due);
            void'(q.pop_front());
        end
        exp_busy = q.size() > 0 && edges >= q[0].e0 && edges < q[0].due;
        exp_done = q.size() > 0 && edges == q[0].due;
        chk("busy", {63'd0, busy}, {63'd0, exp_busy});
        chk("done", {63'd0, done}, {63'd0, exp_done});
        chk("done_busy_excl", {63'd0, done & busy}, 64'd0);
        if (exp_done) last = q.pop_front();
        chk("DivHI", {32'd0, hi}, {32'd0, last.hi});
        chk("DivLO", {32'd0, lo}, {32'd0, last.lo});
        chk("by_zero", {63'd0, bz}, {63'd0, last.bz});
    end

    task automatic go(input logic s, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        start = 1; sg = s; a = x; b = y;
        q.push_back(mk(edges + 1, s, x, y));
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom; sg = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL idle_timeout: got %0d pending expected 0", q.size());
        q.delete();
    endtask

    task automatic lit(input string nm, input logic [31:0] ehi, input logic [31:0] elo, input logic ebz);
        chk({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        chk({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
        chk({nm, "_bz"}, {63'd0, bz}, {63'd0, ebz});
    endtask

    task automatic go8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo);
        int e0, seen;
        logic [64:0] m;
        @(posedge clk); #1;
        start8 = 1; sg8 = s; a8 = x; b8 = y; e0 = edges + 1;
        @(posedge clk); #1;
        start8 = 0; a8 = 8'h5a; b8 = 8'h00;
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            @(negedge clk);
            if (done8) seen = edges;
        end
        m = model(8, s, {24'd0, x}, {24'd0, y});
        chk("w8_latency", 64'(seen), 64'(e0 + 9));
        chk("w8_lo_model", {56'd0, lo8}, {56'd0, m[7:0]});
        chk("w8_hi_model", {56'd0, hi8}, {56'd0, m[39:32]});
        chk("w8_lo", {56'd0, lo8}, {56'd0, elo});
        chk("w8_hi", {56'd0, hi8}, {56'd0, ehi});
        chk("w8_bz", {63'd0, bz8}, 64'd0);
    endtask

    initial begin
        exp_t e1, e2;
        #2 reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("reset", 32'd0, 32'd0, 1'b0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 reset = 1;

        go(0, 32'd100, 32'd7);            wait_idle(); lit("u100_7", 32'd2, 32'd14, 1'b0);
        go(1, 32'hFFFFFFF9, 32'd2);       wait_idle(); lit("sm7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        go(1, 32'd7, 32'hFFFFFFFE);       wait_idle(); lit("s7_m2", 32'd1, 32'hFFFFFFFD, 1'b0);
        go(1, 32'h80000000, 32'hFFFFFFFF); wait_idle(); lit("smin_m1", 32'd0, 32'h80000000, 1'b0);
        go(0, 32'h80000000, 32'hFFFFFFFF); wait_idle(); lit("umin_m1", 32'h80000000, 32'd0, 1'b0);
        go(0, 32'h1234, 32'd0);           wait_idle(); lit("u_div0", 32'h1234, 32'd0, 1'b1);
        go(1, 32'h1234, 32'd0);           wait_idle(); lit("s_div0", 32'h1234, 32'd0, 1'b1);
        go(1, 32'hFFFFFFF0, 32'd0);       wait_idle(); lit("s_div0_neg", 32'hFFFFFFF0, 32'd0, 1'b1);
        go(0, 32'd9, 32'd3);              wait_idle(); lit("clear_bz", 32'd0, 32'd3, 1'b0);

        // start while busy is ignored
        go(0, 32'd100, 32'd7);
        repeat (9) @(posedge clk); #1;
        start = 1; sg = 0; a = 32'd50; b = 32'd5;
        @(posedge clk); #1 start = 0;
        wait_idle(); lit("ignored", 32'd2, 32'd14, 1'b0);

        // start held high: second op begins at the done edge
        @(posedge clk); #1;
        start = 1; sg = 0; a = 32'd100; b = 32'd7;
        e1 = mk(edges + 1, 0, 32'd100, 32'd7);
        q.push_back(e1);
        @(posedge clk); #1;
        a = 32'd50; b = 32'd5;
        e2 = mk(e1.due + 1, 0, 32'd50, 32'd5);
        q.push_back(e2);
        repeat (e2.e0 - edges) @(posedge clk); #1;
        start = 0;
        wait_idle(); lit("held", 32'd0, 32'd10, 1'b0);

        // reset mid-operation abandons it with no done
        go(0, 32'd100, 32'd7);
        repeat (13) @(posedge clk); #1;
        reset = 0;
        q.delete();
        last = '0;
        @(negedge clk);
        lit("midreset", 32'd0, 32'd0, 1'b0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk); #1 reset = 1;
        repeat (3) @(posedge clk);
        go(0, 32'd9, 32'd3); wait_idle(); lit("after_reset", 32'd0, 32'd3, 1'b0);

        go8(0, 8'd200, 8'd3, 8'd2, 8'd66);
        go8(1, 8'h80, 8'hFF, 8'h00, 8'h80);
        go8(1, 8'hF9, 8'h02, 8'hFF, 8'hFD);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
